// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core.
// Holds the main FSM state type, the opcode constants and the mux/ALU-op
// encodings. The ALU decoder and the datapath use the same encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_op_class.sv
// Opcode classifier for the multicycle main FSM (purely combinational).
// Ports:
//   op          in  7  opcode field from the instruction register
//   is_mem      out 1  lw or sw
//   is_load     out 1  lw
//   is_r        out 1  R-type ALU
//   is_i        out 1  I-type ALU
//   is_beq      out 1  beq
//   is_jal      out 1  jal
//   is_illegal  out 1  none of the supported opcodes
module multicycle_op_class
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic       is_mem,
  output logic       is_load,
  output logic       is_r,
  output logic       is_i,
  output logic       is_beq,
  output logic       is_jal,
  output logic       is_illegal
);

  always_comb begin
    is_load    = (op == OP_LW);
    is_mem     = (op == OP_LW) || (op == OP_SW);
    is_r       = (op == OP_R);
    is_i       = (op == OP_I);
    is_beq     = (op == OP_BEQ);
    is_jal     = (op == OP_JAL);
    is_illegal = !(is_mem || is_r || is_i || is_beq || is_jal);
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core (lw, sw, R, I, beq, jal).
// Build option: MULTICYCLE_MEM_WAIT_EN adds the mem_ready handshake; fetch,
// memory read and memory write then hold until mem_ready=1.
// Parameter HALT_ON_ILLEGAL: 1 = S_ILLEGAL is terminal until reset,
//                            0 = S_ILLEGAL lasts one cycle, then S_FETCH.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   op[6:0]         opcode (stable from S_DECODE on)
//   zero            ALU zero flag
//   mem_ready       memory done (MULTICYCLE_MEM_WAIT_EN only)
//   pc_write, adr_src, mem_write, ir_write, result_src[1:0],
//   alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], reg_write   datapath controls
//   illegal_op      high while in S_ILLEGAL
//   retire          pulse in the last cycle of every legal instruction
//
// state      | meaning
// S_FETCH    | read instruction, IR/OldPC load, PC <= PC+4
// S_DECODE   | read regs, precompute branch/jump target
// S_MEMADR   | rs1 + imm address
// S_MEMREAD  | data memory read
// S_MEMWB    | load data to rd
// S_MEMWRITE | data memory write
// S_EXECR    | R-type ALU op
// S_EXECI    | I-type ALU op
// S_ALUWB    | ALUOut to rd
// S_BEQ      | compare, PC <= target if equal
// S_JAL      | PC <= target, ALU forms OldPC+4 for rd
// S_ILLEGAL  | unsupported opcode
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       retire
);

  state_t state, state_nxt;
  logic   mem_rdy;
  logic   is_mem, is_load, is_r, is_i, is_beq, is_jal, is_illegal;
  logic   pc_update, branch, ir_w, mem_w, reg_w, ill, ret;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  multicycle_op_class u_op_class (
    .op         (op),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .is_r       (is_r),
    .is_i       (is_i),
    .is_beq     (is_beq),
    .is_jal     (is_jal),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if      (is_mem)     state_nxt = S_MEMADR;
        else if (is_r)       state_nxt = S_EXECR;
        else if (is_i)       state_nxt = S_EXECI;
        else if (is_beq)     state_nxt = S_BEQ;
        else if (is_jal)     state_nxt = S_JAL;
        else if (is_illegal) state_nxt = S_ILLEGAL;
      end
      S_MEMADR:   state_nxt = is_load ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_nxt = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_nxt = S_ALUWB;
      S_ILLEGAL:  state_nxt = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_OP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ill        = 1'b0;
    ret        = 1'b0;
    case (state)
      S_FETCH: begin
        // IR and PC load only in the cycle memory actually delivers
        ir_w       = mem_rdy;
        pc_update  = mem_rdy;
        result_src = RES_ALURESULT;
        alu_src_b  = SRCB_FOUR;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        ret        = 1'b1;
      end
      S_MEMWRITE: begin
        // write enable stays up through a hold; retire only on exit
        adr_src = 1'b1;
        mem_w   = 1'b1;
        ret     = mem_rdy;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        ret   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_SUB;
        branch    = 1'b1;
        ret       = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_ILLEGAL: ill = 1'b1;
      default: ;
    endcase
  end

  // Reset gates every write strobe so an abandoned instruction leaves no trace
  always_comb begin
    pc_write   = rst_n & (pc_update | (branch & zero));
    ir_write   = rst_n & ir_w;
    mem_write  = rst_n & mem_w;
    reg_write  = rst_n & reg_w;
    illegal_op = rst_n & ill;
    retire     = rst_n & ret;
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: a driver issues random
// instructions and pushes the expected per-cycle control vector; a monitor
// on the falling edge pops and compares. A second instance with
// HALT_ON_ILLEGAL=1 checks the terminal illegal state.
module tb_multicycle_main_fsm;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_ER = 6, P_EI = 7, P_AW = 8, P_B = 9, P_J = 10, P_IL = 11;

  logic clk = 1'b0;
  logic rst_n, rst_h;
  logic [6:0] op, op_h;
  logic zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic mem_ready;
`endif

  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_reg_write, h_illegal_op, h_retire;
  logic [1:0] h_result_src, h_alu_src_a, h_alu_src_b, h_alu_op;

  logic [15:0] exp_q[$];
  logic [15:0] exph_q[$];
  int passed = 0;
  int total = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .illegal_op(illegal_op), .retire(retire)
  );

  multicycle_main_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_h), .op(op_h), .zero(zero),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(h_pc_write), .adr_src(h_adr_src), .mem_write(h_mem_write),
    .ir_write(h_ir_write), .result_src(h_result_src), .alu_src_a(h_alu_src_a),
    .alu_src_b(h_alu_src_b), .alu_op(h_alu_op), .reg_write(h_reg_write),
    .illegal_op(h_illegal_op), .retire(h_retire)
  );

  function automatic logic [15:0] vec(bit pcw, bit adr, bit mw, bit ir,
                                      logic [1:0] rs, logic [1:0] a,
                                      logic [1:0] b, logic [1:0] ao,
                                      bit rw, bit il, bit rt);
    return {pcw, adr, mw, ir, rs, a, b, ao, rw, il, rt};
  endfunction

  // Outputs while rst_n=0: fetch mux settings, no strobes
  function automatic logic [15:0] reset_vec();
    return vec(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
  endfunction

  // Expected control vector for one cycle of a given instruction phase
  function automatic logic [15:0] pv(int p, bit z, bit rdy);
    case (p)
      P_F:   return vec(rdy, 0, 0, rdy, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
      P_D:   return vec(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0);
      P_MA:  return vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0);
      P_MR:  return vec(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      P_MWB: return vec(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 1);
      P_MW:  return vec(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, rdy);
      P_ER:  return vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0);
      P_EI:  return vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0);
      P_AW:  return vec(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1);
      P_B:   return vec(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 1);
      P_J:   return vec(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0);
      P_IL:  return vec(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
      default: return 16'h0;
    endcase
  endfunction

  task automatic cyc(input logic [15:0] e, input logic [15:0] eh);
    exp_q.push_back(e);
    exph_q.push_back(eh);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input int zmode, input int abort_at);
    int ph[$];
    ph.push_back(P_F);
    ph.push_back(P_D);
    case (o)
      LW: begin ph.push_back(P_MA); ph.push_back(P_MR); ph.push_back(P_MWB); end
      SW: begin ph.push_back(P_MA); ph.push_back(P_MW); end
      RT: begin ph.push_back(P_ER); ph.push_back(P_AW); end
      IT: begin ph.push_back(P_EI); ph.push_back(P_AW); end
      BQ: ph.push_back(P_B);
      JL: begin ph.push_back(P_J); ph.push_back(P_AW); end
      default: ph.push_back(P_IL);
    endcase
    op = o;
    foreach (ph[i]) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      if (i == abort_at) begin
        rst_n = 1'b0;
        cyc(reset_vec(), reset_vec());
        rst_n = 1'b1;
        return;
      end
`ifdef MULTICYCLE_MEM_WAIT_EN
      if (ph[i] == P_F || ph[i] == P_MR || ph[i] == P_MW) begin
        int waits;
        bit rdy;
        waits = 0;
        do begin
          rdy = (waits >= 4) || ($urandom_range(0, 2) != 0);
          mem_ready = rdy;
          cyc(pv(ph[i], zero, rdy), reset_vec());
          waits++;
        end while (!rdy);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        cyc(pv(ph[i], zero, 1'b1), reset_vec());
      end
`else
      cyc(pv(ph[i], zero, 1'b1), reset_vec());
`endif
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] o;
    case ($urandom_range(0, 13))
      0, 1:   return LW;
      2, 3:   return SW;
      4, 5:   return RT;
      6, 7:   return IT;
      8, 9:   return BQ;
      10, 11: return JL;
      12:     return 7'b1111111;
      default: begin
        o = 7'($urandom_range(0, 127));
        while (o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL)
          o = 7'($urandom_range(0, 127));
        return o;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    logic [15:0] e, eh, got, goth;
    if (exp_q.size() != 0) begin
      e    = exp_q.pop_front();
      eh   = exph_q.pop_front();
      got  = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
              alu_src_b, alu_op, reg_write, illegal_op, retire};
      goth = {h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_result_src,
              h_alu_src_a, h_alu_src_b, h_alu_op, h_reg_write, h_illegal_op,
              h_retire};
      total++;
      if (got === e) passed++;
      else $display("FAIL main_ctrl cycle=%0d op=%b got=%h expected=%h", cycle, op, got, e);
      total++;
      if (goth === eh) passed++;
      else $display("FAIL halt_ctrl cycle=%0d got=%h expected=%h", cycle, goth, eh);
    end
    cycle++;
  end

  initial begin
    rst_n = 1'b0;
    rst_h = 1'b0;
    op    = 7'h0;
    op_h  = 7'h0;
    zero  = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      zero = 1'($urandom_range(0, 1));
      cyc(reset_vec(), reset_vec());
    end
    rst_n = 1'b1;

    run_instr(LW, 2, -1);
    run_instr(RT, 2, -1);
    run_instr(SW, 2, -1);
    run_instr(BQ, 1, -1);
    run_instr(BQ, 0, -1);
    run_instr(IT, 2, -1);
    run_instr(JL, 2, -1);
    run_instr(7'b1111111, 2, -1);
    run_instr(LW, 2, 3);

    for (int n = 0; n < 200; n++) begin
      logic [6:0] o;
      o = rand_op();
      if ($urandom_range(0, 11) == 0) run_instr(o, 2, int'($urandom_range(1, 2)));
      else run_instr(o, 2, -1);
    end

    // Terminal illegal state on the halting instance; main held in reset
    rst_n = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    cyc(reset_vec(), reset_vec());
    rst_h = 1'b1;
    op_h  = 7'b1111111;
    cyc(reset_vec(), pv(P_F, 1'b0, 1'b1));
    cyc(reset_vec(), pv(P_D, 1'b0, 1'b1));
    for (int i = 0; i < 6; i++) begin
      op_h = 7'($urandom_range(0, 127));
      cyc(reset_vec(), pv(P_IL, 1'b0, 1'b1));
    end
    rst_h = 1'b0;
    cyc(reset_vec(), reset_vec());
    rst_h = 1'b1;
    op_h  = IT;
    cyc(reset_vec(), pv(P_F, 1'b0, 1'b1));
    cyc(reset_vec(), pv(P_D, 1'b0, 1'b1));
    cyc(reset_vec(), pv(P_EI, 1'b0, 1'b1));

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
